// File: rtl/line_mem_master.sv
// line_mem_master: initiator for the 128-bit line memory port.
// It services one cache-line miss at a time. Each miss can run an optional
// victim writeback, then a one-cycle bus turnaround, then an optional refill
// read. It reports completion, or an abort when the memory stops answering.
module line_mem_master #(
  parameter int ADDR_W  = 28,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dirty,
  input  logic              req_rd_en,
  input  logic [ADDR_W-1:0] req_wb_addr,
  input  logic [127:0]      req_wb_data,
  input  logic [ADDR_W-1:0] req_rd_addr,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [127:0]      resp_rdata,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WB   = 3'd1,
    S_GAP  = 3'd2,
    S_RD   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Counter value seen during the last allowed request cycle.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [127:0]      mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [127:0]      resp_rdata_q, resp_rdata_d;

  logic              req_phase;
  logic              to_hit;
  logic              rd_en_eff;
  logic [ADDR_W-1:0] rd_addr_eff;

  // A request is outstanding in WB or RD. Ready in the last cycle still wins.
  assign req_phase = (state_q == S_WB) || (state_q == S_RD);
  assign to_hit    = req_phase && !mem_ready && (cnt_q == CNT_LAST);

  // In IDLE the refill fields come straight from the command port.
  // The captured copies are only valid from the following cycle.
  assign rd_en_eff   = (state_q == S_IDLE) ? req_rd_en   : rd_en_q;
  assign rd_addr_eff = (state_q == S_IDLE) ? req_rd_addr : rd_addr_q;

  // State, timeout counter and all registered outputs; reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Captured refill command; pure datapath, so it has no reset.
  always_ff @(posedge clk) begin
    rd_en_q   <= rd_en_d;
    rd_addr_q <= rd_addr_d;
  end

  // Next state, command capture and timeout counter.
  // The victim address and data go straight into the memory output
  // registers on accept, so they need no separate copy.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rd_en_d   = req_rd_en;
          rd_addr_d = req_rd_addr;
          if (req_dirty)      state_d = S_WB;
          else if (req_rd_en) state_d = S_RD;
          else                state_d = S_DONE;
        end
      end
      S_WB: begin
        if (mem_ready)   state_d = S_GAP;
        else if (to_hit) state_d = S_DONE;
      end
      S_GAP:   state_d = rd_en_q ? S_RD : S_DONE;
      S_RD: begin
        if (mem_ready || to_hit) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if ((state_d != state_q) && ((state_d == S_WB) || (state_d == S_RD))) begin
      cnt_d = '0;
    end else if (req_phase && !mem_ready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Registered outputs follow the state being entered.
  // Address and write data hold their values between requests.
  // The response pulse lands in the cycle after DONE.
  always_comb begin
    mem_read_d   = (state_d == S_RD);
    mem_write_d  = (state_d == S_WB);
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = (state_q == S_DONE);
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    if ((state_q == S_IDLE) && (state_d == S_WB)) begin
      mem_addr_d  = req_wb_addr;
      mem_wdata_d = req_wb_data;
    end else if ((state_q != S_RD) && (state_d == S_RD) && rd_en_eff) begin
      mem_addr_d = rd_addr_eff;
    end

    if ((state_q == S_RD) && mem_ready) begin
      resp_rdata_d = mem_rdata;
    end else if (to_hit) begin
      resp_rdata_d = '0;
    end

    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      resp_err_d = to_hit;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule
